// File: rtl/bp_perf_pkg.sv
// Shared types and constants for the branch-predictor measurement controller.
package bp_perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } perf_state_e;

  typedef enum logic [1:0] {
    SEL_CYC   = 2'd0,
    SEL_INSTR = 2'd1,
    SEL_BR    = 2'd2,
    SEL_MISS  = 2'd3
  } rd_sel_e;

  // jal x0,0: the self-loop the test programs park on when finished.
  localparam logic [31:0] HALT_JAL_SELF = 32'h0000006F;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating event counter with synchronous clear; sat_o pulses when an
// increment arrives while the counter already holds all-ones.
module bp_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        sat_o = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/bp_perf_monitor.sv
// Measurement-window sequencer for branch-predictor evaluation: optional
// warm-up, then cycle/instruction/branch/miss counting until stop or halt.
//
// Handshake: start_i and stop_i are single-cycle pulses sampled on the rising
// edge with no ready/ack; start_i is honoured only in IDLE/DONE (and wins over
// a simultaneous stop_i there), stop_i only in WARMUP/RUN.
module bp_perf_monitor
  import bp_perf_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          WARMUP_CYC = 0,
  parameter logic [31:0] HALT_INSN  = HALT_JAL_SELF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             instr_vld_i,
  input  logic [31:0]      instr_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [1:0]       dbg_state_o
);

  localparam int WU_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC + 1) : 1;
  localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP_CYC);

  perf_state_e     state_q, state_d;
  logic [WU_W-1:0] wu_q, wu_d;
  logic            ovf_q, ovf_d;
  logic            cnt_clr;
  logic            counting;
  logic            halt_seen;
  logic [3:0]      cnt_inc;
  logic [3:0]      cnt_sat;
  logic [CNT_W-1:0] cnt_q [4];

  // Halt only matters in WARMUP/RUN; the gating keeps X on the fetch bus
  // from reaching state while the window is closed.
  assign halt_seen = instr_vld_i && (instr_i == HALT_INSN);
  assign counting  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          cnt_clr = 1'b1;
          wu_d    = WU_LOAD;
          state_d = (WARMUP_CYC > 0) ? WARMUP : RUN;
        end
      end
      WARMUP: begin
        if (stop_i || halt_seen) begin
          state_d = DONE;
        end else begin
          wu_d = wu_q - WU_W'(1);
          if (wu_q == WU_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop_i || halt_seen) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wu_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      ovf_q   <= ovf_d;
    end
  end

  // Bit order follows rd_sel_e: cycles, instructions, branches, misses.
  assign cnt_inc = {counting & br_miss_i,
                    counting & br_instr_i,
                    counting & instr_vld_i,
                    counting};

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    bp_sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc[i]),
      .q_o   (cnt_q[i]),
      .sat_o (cnt_sat[i])
    );
  end

  always_comb begin
    ovf_d = cnt_clr ? 1'b0 : (ovf_q | (|cnt_sat));
  end

  always_comb begin
    rd_o = '0;
    case (rd_sel_e'(rd_sel_i))
      SEL_CYC:   rd_o = cnt_q[0];
      SEL_INSTR: rd_o = cnt_q[1];
      SEL_BR:    rd_o = cnt_q[2];
      SEL_MISS:  rd_o = cnt_q[3];
      default:   rd_o = '0;
    endcase
  end

  assign busy_o      = (state_q == WARMUP) || (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Bench for bp_perf_monitor: three instances (no warm-up, 4-cycle warm-up,
// 4-bit counters) share one stimulus stream and are checked against a model.
module tb_bp_perf_monitor;
  import bp_perf_pkg::*;

  localparam logic [31:0] HALT = 32'h0000006F;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, instr_vld_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        br_instr_i = 1'b0, br_miss_i = 1'b0;
  logic [1:0]  rd_sel_i = '0;

  logic [31:0] rd0, rd4;
  logic [3:0]  rds;
  logic        busy0, busy4, busys, done0, done4, dones, ovf0, ovf4, ovfs;
  logic [1:0]  st0, st4, sts;

  logic [31:0] rd_a   [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic        ovf_a  [3];
  logic [1:0]  st_a   [3];

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, whether the window is open/finished,
  // warm-up cycles still to skip, the four counts and the sticky overflow.
  int              wid     [3] = '{32, 32, 4};
  int              wu_cfg  [3] = '{0, 4, 0};
  bit              m_open  [3];
  bit              m_fin   [3];
  int              m_warm  [3];
  bit              m_ovf   [3];
  longint unsigned m_cnt   [3][4];

  typedef struct {
    logic        start, stop, vld;
    logic [31:0] instr;
    logic        br, miss;
    logic [1:0]  sel;
    logic        exp_busy, exp_done;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [15];

  always #5 clk_i = ~clk_i;

  bp_perf_monitor #(.CNT_W(32), .WARMUP_CYC(0)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .instr_vld_i(instr_vld_i), .instr_i(instr_i), .br_instr_i(br_instr_i),
    .br_miss_i(br_miss_i), .rd_sel_i(rd_sel_i), .rd_o(rd0), .busy_o(busy0),
    .done_o(done0), .ovf_o(ovf0), .dbg_state_o(st0));

  bp_perf_monitor #(.CNT_W(32), .WARMUP_CYC(4)) u4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .instr_vld_i(instr_vld_i), .instr_i(instr_i), .br_instr_i(br_instr_i),
    .br_miss_i(br_miss_i), .rd_sel_i(rd_sel_i), .rd_o(rd4), .busy_o(busy4),
    .done_o(done4), .ovf_o(ovf4), .dbg_state_o(st4));

  bp_perf_monitor #(.CNT_W(4), .WARMUP_CYC(0)) us (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .instr_vld_i(instr_vld_i), .instr_i(instr_i), .br_instr_i(br_instr_i),
    .br_miss_i(br_miss_i), .rd_sel_i(rd_sel_i), .rd_o(rds), .busy_o(busys),
    .done_o(dones), .ovf_o(ovfs), .dbg_state_o(sts));

  assign rd_a[0] = rd0;  assign rd_a[1] = rd4;  assign rd_a[2] = {28'd0, rds};
  assign busy_a[0] = busy0; assign busy_a[1] = busy4; assign busy_a[2] = busys;
  assign done_a[0] = done0; assign done_a[1] = done4; assign done_a[2] = dones;
  assign ovf_a[0] = ovf0;   assign ovf_a[1] = ovf4;   assign ovf_a[2] = ovfs;
  assign st_a[0] = st0;     assign st_a[1] = st4;     assign st_a[2] = sts;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic s, p, v, input logic [31:0] ins,
                              input logic b, m, input logic [1:0] sel,
                              input logic eb, ed, input logic [31:0] er);
    vec_t r;
    r.start = s; r.stop = p; r.vld = v; r.instr = ins; r.br = b; r.miss = m;
    r.sel = sel; r.exp_busy = eb; r.exp_done = ed; r.exp_rd = er;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_open[k] = 1'b0; m_fin[k] = 1'b0; m_warm[k] = 0; m_ovf[k] = 1'b0;
      for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
    end
  endtask

  task automatic bump(input int k, input int c, input logic ev);
    longint unsigned mx;
    mx = (64'd1 << wid[k]) - 64'd1;
    if (ev === 1'b1) begin
      if (m_cnt[k][c] == mx) m_ovf[k] = 1'b1;
      else m_cnt[k][c] = m_cnt[k][c] + 1;
    end
  endtask

  task automatic model_step();
    bit halt;
    for (int k = 0; k < 3; k++) begin
      if (!m_open[k]) begin
        if (start_i === 1'b1) begin
          m_open[k] = 1'b1; m_fin[k] = 1'b0; m_ovf[k] = 1'b0;
          m_warm[k] = wu_cfg[k];
          for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
        end
      end else begin
        halt = (instr_vld_i === 1'b1) && (instr_i === HALT);
        if (m_warm[k] > 0) begin
          if (stop_i === 1'b1 || halt) begin m_open[k] = 1'b0; m_fin[k] = 1'b1; end
          else m_warm[k]--;
        end else begin
          bump(k, 0, 1'b1);
          bump(k, 1, instr_vld_i);
          bump(k, 2, br_instr_i);
          bump(k, 3, br_miss_i);
          if (stop_i === 1'b1 || halt) begin m_open[k] = 1'b0; m_fin[k] = 1'b1; end
        end
      end
    end
  endtask

  task automatic check_model();
    perf_state_e es;
    for (int k = 0; k < 3; k++) begin
      if (m_open[k]) es = (m_warm[k] > 0) ? WARMUP : RUN;
      else es = m_fin[k] ? DONE : IDLE;
      chk($sformatf("m%0d_busy", k), 64'(busy_a[k]), 64'(m_open[k]));
      chk($sformatf("m%0d_done", k), 64'(done_a[k]), 64'(m_fin[k] && !m_open[k]));
      chk($sformatf("m%0d_ovf", k),  64'(ovf_a[k]),  64'(m_ovf[k]));
      chk($sformatf("m%0d_state", k), 64'(st_a[k]), 64'(es));
      chk($sformatf("m%0d_rd_sel%0d", k, rd_sel_i), 64'(rd_a[k]),
          64'(m_cnt[k][rd_sel_i]));
    end
  endtask

  // Inputs are driven at posedge+1; outputs are compared at the negedge.
  task automatic tick();
    @(negedge clk_i);
    check_model();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic s, p, v, input logic [31:0] ins,
                       input logic b, m, input logic [1:0] sel);
    start_i = s; stop_i = p; instr_vld_i = v; instr_i = ins;
    br_instr_i = b; br_miss_i = m; rd_sel_i = sel;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 2'd0);
  endtask

  // Peek one instance counter through rd_sel at the current time.
  task automatic peek(input string nm, input int k, input logic [1:0] sel,
                      input logic [31:0] exp);
    rd_sel_i = sel;
    #0.1;
    chk(nm, 64'(rd_a[k]), 64'(exp));
  endtask

  initial begin
    // Vectors for the 10-cycle window on the no-warm-up instance, then a
    // readback with X on every event input while DONE.
    vecs[0]  = mk(1, 0, 0, NOP, 0, 0, 2'd0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 1, NOP, 0, 0, 2'd1, 1, 0, 1);
    vecs[2]  = mk(0, 0, 1, NOP, 1, 0, 2'd2, 1, 0, 1);
    vecs[3]  = mk(0, 0, 0, NOP, 0, 0, 2'd3, 1, 0, 0);
    vecs[4]  = mk(0, 0, 1, NOP, 0, 0, 2'd0, 1, 0, 4);
    vecs[5]  = mk(0, 0, 1, NOP, 1, 0, 2'd1, 1, 0, 4);
    vecs[6]  = mk(0, 0, 0, NOP, 0, 0, 2'd2, 1, 0, 2);
    vecs[7]  = mk(0, 0, 1, NOP, 0, 0, 2'd3, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, NOP, 1, 1, 2'd0, 1, 0, 8);
    vecs[9]  = mk(0, 0, 1, NOP, 0, 0, 2'd1, 1, 0, 6);
    vecs[10] = mk(0, 1, 0, NOP, 0, 0, 2'd2, 0, 1, 3);
    vecs[11] = mk(0, 'x, 'x, 'x, 'x, 'x, 2'd0, 0, 1, 10);
    vecs[12] = mk(0, 'x, 'x, 'x, 'x, 'x, 2'd1, 0, 1, 6);
    vecs[13] = mk(0, 'x, 'x, 'x, 'x, 'x, 2'd2, 0, 1, 3);
    vecs[14] = mk(0, 'x, 'x, 'x, 'x, 'x, 2'd3, 0, 1, 1);

    model_reset();
    idle_in();
    repeat (3) @(posedge clk_i);
    for (int s = 0; s < 4; s++) peek($sformatf("reset_rd_sel%0d", s), 0, 2'(s), 0);
    chk("reset_busy", 64'(busy0), 0);
    chk("reset_done", 64'(done0), 0);
    chk("reset_ovf", 64'(ovf0), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Asynchronous reset in the middle of a RUN window.
    drive(1, 0, 0, NOP, 0, 0, 2'd0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, NOP, 1, 1, 2'd0); tick();
    end
    peek("run5_cycles", 0, 2'd0, 5);
    peek("run5_misses", 0, 2'd3, 5);
    idle_in();
    #2 rst_i = 1'b1;
    #0.5;
    chk("arst_busy", 64'(busy0), 0);
    chk("arst_done", 64'(done0), 0);
    for (int s = 0; s < 4; s++) peek($sformatf("arst_rd_sel%0d", s), 0, 2'(s), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].vld, vecs[i].instr,
            vecs[i].br, vecs[i].miss, vecs[i].sel);
      tick();
      chk($sformatf("vec%0d_busy", i), 64'(busy0), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 64'(done0), 64'(vecs[i].exp_done));
      chk($sformatf("vec%0d_rd", i), 64'(rd0), 64'(vecs[i].exp_rd));
    end

    // Warm-up cycles must not count branches.
    drive(1, 0, 0, NOP, 0, 0, 2'd2); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, NOP, 1, 0, 2'd2); tick();
    end
    peek("warm_branches", 1, 2'd2, 0);
    peek("warm_cycles", 1, 2'd0, 0);
    chk("warm_busy", 64'(busy4), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, NOP, 1, 0, 2'd2); tick();
    end
    peek("run3_branches", 1, 2'd2, 3);
    peek("run3_cycles", 1, 2'd0, 3);
    drive(0, 1, 0, NOP, 0, 0, 2'd0); tick();

    // Halt fetched on cycle 7 closes the window and is itself counted.
    drive(1, 0, 0, NOP, 0, 0, 2'd0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, NOP, 0, 0, 2'd0); tick();
    end
    chk("pre_halt_busy", 64'(busy0), 1);
    drive(0, 0, 1, HALT, 0, 0, 2'd0); tick();
    chk("halt_done", 64'(done0), 1);
    peek("halt_cycles", 0, 2'd0, 7);
    peek("halt_instrs", 0, 2'd1, 7);

    // 4-bit cycle counter saturates at 15; a new start clears overflow.
    drive(1, 0, 0, NOP, 0, 0, 2'd0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, (i == 19), 0, NOP, 0, 0, 2'd0); tick();
    end
    peek("sat_cycles", 2, 2'd0, 15);
    chk("sat_ovf", 64'(ovfs), 1);
    chk("wide_no_ovf", 64'(ovf0), 0);
    peek("wide_cycles", 0, 2'd0, 20);
    drive(1, 0, 0, NOP, 0, 0, 2'd0); tick();
    chk("restart_ovf", 64'(ovfs), 0);
    peek("restart_cycles", 2, 2'd0, 0);
    drive(0, 1, 0, NOP, 0, 0, 2'd0); tick();

    // start+stop together: start wins when closed, stop wins in RUN.
    drive(1, 1, 0, NOP, 0, 0, 2'd0); tick();
    chk("ss_idle_busy", 64'(busy0), 1);
    chk("ss_idle_state", 64'(st0), 64'(RUN));
    for (int i = 0; i < 3; i++) begin
      idle_in(); tick();
    end
    drive(1, 0, 0, NOP, 0, 0, 2'd0); tick();
    peek("start_in_run_cycles", 0, 2'd0, 4);
    chk("start_in_run_busy", 64'(busy0), 1);
    drive(1, 1, 0, NOP, 0, 0, 2'd0); tick();
    chk("ss_run_done", 64'(done0), 1);
    peek("ss_run_cycles", 0, 2'd0, 5);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 59) == 0) ? HALT : 32'($urandom),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)));
      tick();
    end
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
